// File: rtl/bp_be_pkg.sv
// Shared types for the backend register-file read arbiter: FSM state and operand tags.
package bp_be_pkg;

    typedef enum logic {
        e_idle   = 1'b0,
        e_second = 1'b1
    } rf_arb_state_e;

    // Operand slot index: 0 = s0.rs1, 1 = s0.rs2, 2 = s1.rs1, 3 = s1.rs2
    typedef logic [1:0] opd_tag_t;

    localparam int unsigned num_opd_lp  = 4;
    localparam int unsigned num_port_lp = 2;

endpackage

// File: rtl/bp_be_rf_req_packer.sv
// Priority packer: picks the two lowest set bits of a 4-bit request vector,
// returns their tags and the requests left over for a second pass.
module bp_be_rf_req_packer
    import bp_be_pkg::*;
(
    input  logic [3:0] req_i,
    output logic [1:0] v_o,
    output logic [1:0] tag0_o,
    output logic [1:0] tag1_o,
    output logic [3:0] residual_o
);

    always_comb begin
        v_o        = 2'b00;
        tag0_o     = 2'd0;
        tag1_o     = 2'd0;
        residual_o = req_i;
        for (int i = 0; i < 4; i++) begin
            if (req_i[i]) begin
                if (!v_o[0]) begin
                    v_o[0]        = 1'b1;
                    tag0_o        = opd_tag_t'(i);
                    residual_o[i] = 1'b0;
                end else if (!v_o[1]) begin
                    v_o[1]        = 1'b1;
                    tag1_o        = opd_tag_t'(i);
                    residual_o[i] = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/bp_be_rf_read_arbiter.sv
// Two-port register-file read arbiter for a dual-issue pair: up to four operand
// reads, served in one pass or split across two cycles when more than two are needed.
module bp_be_rf_read_arbiter
    import bp_be_pkg::*;
#(
    parameter int addr_width_p      = 5,
    parameter int data_width_p      = 64,
    parameter int split_cnt_width_p = 16
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic                           flush_i,
    input  logic                           pair_v_i,
    output logic                           pair_ready_o,
    input  logic [3:0]                     rs_v_i,
    input  logic [4*addr_width_p-1:0]      rs_addr_i,
    output logic [1:0]                     rf_r_v_o,
    output logic [2*addr_width_p-1:0]      rf_addr_o,
    input  logic [2*data_width_p-1:0]      rf_data_i,
    output logic                           opd_v_o,
    output logic [4*data_width_p-1:0]      opd_o,
    output logic [split_cnt_width_p-1:0]   split_cnt_o
);

    logic [3:0][addr_width_p-1:0] addr_a;
    logic [1:0][data_width_p-1:0] rdata;
    logic [3:0]                   eff_req;

    assign addr_a = rs_addr_i;
    assign rdata  = rf_data_i;

    for (genvar gi = 0; gi < 4; gi++) begin : g_eff
        assign eff_req[gi] = rs_v_i[gi] & (|addr_a[gi]);
    end

    rf_arb_state_e                state_q, state_d;
    logic                         pend_q, pend_d;
    logic                         final_q, final_d;
    logic [1:0]                   rd_v_q, rd_v_d;
    opd_tag_t [1:0]               rd_tag_q, rd_tag_d;
    logic [3:0]                   sec_mask_q, sec_mask_d;
    logic [3:0][addr_width_p-1:0] sec_addr_q, sec_addr_d;
    logic [3:0][data_width_p-1:0] hold_q, hold_d;
    logic [split_cnt_width_p-1:0] split_cnt_q, split_cnt_d;

    logic [3:0]                   pk_in;
    logic [1:0]                   pk_v;
    opd_tag_t                     pk_tag0, pk_tag1;
    logic [3:0]                   pk_res;
    logic [3:0][addr_width_p-1:0] addr_sel;
    logic [1:0][addr_width_p-1:0] port_addr;
    logic [3:0][data_width_p-1:0] merged;
    logic                         accept;
    logic                         in_second;

    // One packer serves both passes: fresh requests when idle, the registered remainder in e_second.
    bp_be_rf_req_packer u_packer (
        .req_i      (pk_in),
        .v_o        (pk_v),
        .tag0_o     (pk_tag0),
        .tag1_o     (pk_tag1),
        .residual_o (pk_res)
    );

    assign in_second    = (state_q == e_second);
    assign pair_ready_o = (state_q == e_idle) & ~flush_i & reset_n_i;
    assign accept       = pair_v_i & pair_ready_o;

    // Latest port data wins over held pass-1 values for the tagged operand.
    for (genvar gi = 0; gi < 4; gi++) begin : g_merge
        assign merged[gi] = (rd_v_q[1] && rd_tag_q[1] == opd_tag_t'(gi)) ? rdata[1] :
                            (rd_v_q[0] && rd_tag_q[0] == opd_tag_t'(gi)) ? rdata[0] :
                            hold_q[gi];
    end

    assign opd_v_o     = pend_q & final_q & ~flush_i;
    assign opd_o       = opd_v_o ? merged : '0;
    assign rf_addr_o   = port_addr;
    assign split_cnt_o = split_cnt_q;

    always_comb begin
        pk_in    = in_second ? sec_mask_q : eff_req;
        addr_sel = in_second ? sec_addr_q : addr_a;

        rf_r_v_o  = 2'b00;
        port_addr = '0;
        if (accept || (in_second && !flush_i)) begin
            rf_r_v_o = pk_v;
        end
        if (rf_r_v_o[0]) port_addr[0] = addr_sel[pk_tag0];
        if (rf_r_v_o[1]) port_addr[1] = addr_sel[pk_tag1];

        state_d     = state_q;
        pend_d      = 1'b0;
        final_d     = 1'b0;
        rd_v_d      = 2'b00;
        rd_tag_d    = '0;
        sec_mask_d  = sec_mask_q;
        sec_addr_d  = sec_addr_q;
        hold_d      = hold_q;
        split_cnt_d = split_cnt_q;

        if (flush_i) begin
            state_d    = e_idle;
            sec_mask_d = '0;
            sec_addr_d = '0;
            hold_d     = '0;
        end else if (in_second) begin
            rd_v_d     = pk_v;
            rd_tag_d   = {pk_tag1, pk_tag0};
            pend_d     = 1'b1;
            final_d    = 1'b1;
            state_d    = e_idle;
            hold_d     = merged;
            sec_mask_d = '0;
            sec_addr_d = '0;
        end else if (accept) begin
            rd_v_d     = pk_v;
            rd_tag_d   = {pk_tag1, pk_tag0};
            pend_d     = 1'b1;
            final_d    = ~|pk_res;
            hold_d     = '0;
            sec_mask_d = pk_res;
            for (int i = 0; i < 4; i++) begin
                sec_addr_d[i] = pk_res[i] ? addr_a[i] : '0;
            end
            if (|pk_res) begin
                state_d = e_second;
                if (!(&split_cnt_q)) split_cnt_d = split_cnt_q + split_cnt_width_p'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= e_idle;
            pend_q      <= 1'b0;
            final_q     <= 1'b0;
            rd_v_q      <= 2'b00;
            rd_tag_q    <= '0;
            sec_mask_q  <= '0;
            sec_addr_q  <= '0;
            hold_q      <= '0;
            split_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            final_q     <= final_d;
            rd_v_q      <= rd_v_d;
            rd_tag_q    <= rd_tag_d;
            sec_mask_q  <= sec_mask_d;
            sec_addr_q  <= sec_addr_d;
            hold_q      <= hold_d;
            split_cnt_q <= split_cnt_d;
        end
    end

endmodule

// File: tb/tb_bp_be_rf_read_arbiter.sv
// Directed bench for bp_be_rf_read_arbiter with a small behavioural register file.
module tb_bp_be_rf_read_arbiter;

    localparam int AW = 5;
    localparam int DW = 64;
    localparam int CW = 4;

    logic                 clk;
    logic                 reset_n;
    logic                 flush;
    logic                 pair_v;
    logic                 pair_ready;
    logic [3:0]           rs_v;
    logic [3:0][AW-1:0]   rs_addr;
    logic [1:0]           rf_r_v;
    logic [2*AW-1:0]      rf_addr;
    logic [2*DW-1:0]      rf_data;
    logic                 opd_v;
    logic [4*DW-1:0]      opd;
    logic [CW-1:0]        split_cnt;

    int checks = 0;
    int errors = 0;

    bp_be_rf_read_arbiter #(
        .addr_width_p      (AW),
        .data_width_p      (DW),
        .split_cnt_width_p (CW)
    ) dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .flush_i      (flush),
        .pair_v_i     (pair_v),
        .pair_ready_o (pair_ready),
        .rs_v_i       (rs_v),
        .rs_addr_i    (rs_addr),
        .rf_r_v_o     (rf_r_v),
        .rf_addr_o    (rf_addr),
        .rf_data_i    (rf_data),
        .opd_v_o      (opd_v),
        .opd_o        (opd),
        .split_cnt_o  (split_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] val(input logic [4:0] a);
        return 64'hC0DE_0000_0000_0000 | (64'(a) << 32) | (64'(a) * 64'h0000_0000_0001_0101);
    endfunction

    // Register file: data appears the cycle after the read enable.
    always_ff @(posedge clk) begin
        rf_data[DW-1:0]    <= rf_r_v[0] ? val(rf_addr[AW-1:0])    : 64'd0;
        rf_data[2*DW-1:DW] <= rf_r_v[1] ? val(rf_addr[2*AW-1:AW]) : 64'd0;
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pair(input logic v, input logic [3:0] rv,
                            input logic [4:0] a0, input logic [4:0] a1,
                            input logic [4:0] a2, input logic [4:0] a3);
        pair_v     = v;
        rs_v       = rv;
        rs_addr[0] = a0;
        rs_addr[1] = a1;
        rs_addr[2] = a2;
        rs_addr[3] = a3;
    endtask

    initial begin
        reset_n = 1'b0;
        flush   = 1'b0;
        set_pair(1'b0, 4'b0000, 5'd0, 5'd0, 5'd0, 5'd0);
        repeat (2) @(posedge clk);
        #1;
        pair_v = 1'b1;
        #1;
        chk("rst_ready", 256'(pair_ready), 256'd0);
        chk("rst_rv", 256'(rf_r_v), 256'd0);
        chk("rst_opdv", 256'(opd_v), 256'd0);
        chk("rst_opd", opd, 256'd0);
        chk("rst_cnt", 256'(split_cnt), 256'd0);
        pair_v  = 1'b0;
        reset_n = 1'b1;
        next_cyc();
        $display("txn reset done");

        // Sparse pair: s0.rs1=x3, s1.rs2=x7
        set_pair(1'b1, 4'b1001, 5'd3, 5'd9, 5'd0, 5'd7);
        #1;
        chk("t1_ready", 256'(pair_ready), 256'd1);
        chk("t1_rv", 256'(rf_r_v), 256'd3);
        chk("t1_addr", 256'(rf_addr), 256'({5'd7, 5'd3}));
        chk("t1_opdv0", 256'(opd_v), 256'd0);
        next_cyc();
        set_pair(1'b0, 4'b0000, 5'd0, 5'd0, 5'd0, 5'd0);
        #1;
        chk("t1_opdv", 256'(opd_v), 256'd1);
        chk("t1_opd", opd, {val(5'd7), 64'd0, 64'd0, val(5'd3)});
        chk("t1_idle_rv", 256'(rf_r_v), 256'd0);
        chk("t1_idle_addr", 256'(rf_addr), 256'd0);
        next_cyc();
        chk("t1_opdv_after", 256'(opd_v), 256'd1 - 256'd1);
        chk("t1_opd_zero", opd, 256'd0);
        $display("txn sparse pair x3/x7");

        // Full split pair x1..x4
        set_pair(1'b1, 4'b1111, 5'd1, 5'd2, 5'd3, 5'd4);
        #1;
        chk("t2_c0_rv", 256'(rf_r_v), 256'd3);
        chk("t2_c0_addr", 256'(rf_addr), 256'({5'd2, 5'd1}));
        next_cyc();
        chk("t2_c1_ready", 256'(pair_ready), 256'd0);
        chk("t2_c1_rv", 256'(rf_r_v), 256'd3);
        chk("t2_c1_addr", 256'(rf_addr), 256'({5'd4, 5'd3}));
        chk("t2_c1_opdv", 256'(opd_v), 256'd0);
        next_cyc();
        set_pair(1'b0, 4'b0000, 5'd0, 5'd0, 5'd0, 5'd0);
        #1;
        chk("t2_opdv", 256'(opd_v), 256'd1);
        chk("t2_opd", opd, {val(5'd4), val(5'd3), val(5'd2), val(5'd1)});
        chk("t2_cnt", 256'(split_cnt), 256'd1);
        next_cyc();
        $display("txn split pair x1..x4");

        // x0 reads are dropped: single pass
        set_pair(1'b1, 4'b1111, 5'd0, 5'd0, 5'd5, 5'd6);
        #1;
        chk("t3_rv", 256'(rf_r_v), 256'd3);
        chk("t3_addr", 256'(rf_addr), 256'({5'd6, 5'd5}));
        next_cyc();
        set_pair(1'b0, 4'b0000, 5'd0, 5'd0, 5'd0, 5'd0);
        #1;
        chk("t3_opdv", 256'(opd_v), 256'd1);
        chk("t3_opd", opd, {val(5'd6), val(5'd5), 64'd0, 64'd0});
        chk("t3_cnt", 256'(split_cnt), 256'd1);
        chk("t3_ready", 256'(pair_ready), 256'd1);
        next_cyc();
        $display("txn x0 pair x5/x6");

        // No effective requests
        set_pair(1'b1, 4'b0000, 5'd8, 5'd8, 5'd8, 5'd8);
        #1;
        chk("t4_rv", 256'(rf_r_v), 256'd0);
        next_cyc();
        set_pair(1'b0, 4'b0000, 5'd0, 5'd0, 5'd0, 5'd0);
        #1;
        chk("t4_opdv", 256'(opd_v), 256'd1);
        chk("t4_opd", opd, 256'd0);
        next_cyc();
        $display("txn empty pair");

        // Back-to-back single-pass pairs
        set_pair(1'b1, 4'b0001, 5'd10, 5'd0, 5'd0, 5'd0);
        next_cyc();
        set_pair(1'b1, 4'b0010, 5'd0, 5'd11, 5'd0, 5'd0);
        #1;
        chk("t5_a_opdv", 256'(opd_v), 256'd1);
        chk("t5_a_opd", opd, {64'd0, 64'd0, 64'd0, val(5'd10)});
        chk("t5_b_ready", 256'(pair_ready), 256'd1);
        chk("t5_b_addr", 256'(rf_addr), 256'({5'd0, 5'd11}));
        next_cyc();
        set_pair(1'b0, 4'b0000, 5'd0, 5'd0, 5'd0, 5'd0);
        #1;
        chk("t5_b_opd", opd, {64'd0, 64'd0, val(5'd11), 64'd0});
        next_cyc();
        $display("txn back-to-back x10 then x11");

        // Flush in the second pass
        set_pair(1'b1, 4'b1111, 5'd12, 5'd13, 5'd14, 5'd15);
        next_cyc();
        set_pair(1'b0, 4'b0000, 5'd0, 5'd0, 5'd0, 5'd0);
        flush = 1'b1;
        #1;
        chk("t6_fl_rv", 256'(rf_r_v), 256'd0);
        chk("t6_fl_ready", 256'(pair_ready), 256'd0);
        next_cyc();
        flush = 1'b0;
        set_pair(1'b1, 4'b0001, 5'd16, 5'd0, 5'd0, 5'd0);
        #1;
        chk("t6_opdv_none", 256'(opd_v), 256'd0);
        chk("t6_ready", 256'(pair_ready), 256'd1);
        chk("t6_cnt", 256'(split_cnt), 256'd2);
        next_cyc();
        set_pair(1'b0, 4'b0000, 5'd0, 5'd0, 5'd0, 5'd0);
        #1;
        chk("t6_next_opd", opd, {64'd0, 64'd0, 64'd0, val(5'd16)});
        next_cyc();
        $display("txn flush mid-split then x16");

        // Flush in the offer cycle blocks the accept
        set_pair(1'b1, 4'b0001, 5'd17, 5'd0, 5'd0, 5'd0);
        flush = 1'b1;
        #1;
        chk("t7_ready", 256'(pair_ready), 256'd0);
        chk("t7_rv", 256'(rf_r_v), 256'd0);
        next_cyc();
        flush = 1'b0;
        set_pair(1'b0, 4'b0000, 5'd0, 5'd0, 5'd0, 5'd0);
        #1;
        chk("t7_opdv", 256'(opd_v), 256'd0);
        next_cyc();
        $display("txn flush blocks accept");

        // Asynchronous reset in the second pass
        set_pair(1'b1, 4'b1111, 5'd1, 5'd2, 5'd3, 5'd4);
        next_cyc();
        set_pair(1'b0, 4'b0000, 5'd0, 5'd0, 5'd0, 5'd0);
        #1;
        reset_n = 1'b0;
        #1;
        chk("t8_rv", 256'(rf_r_v), 256'd0);
        chk("t8_cnt", 256'(split_cnt), 256'd0);
        chk("t8_ready", 256'(pair_ready), 256'd0);
        next_cyc();
        reset_n = 1'b1;
        #1;
        chk("t8_opdv1", 256'(opd_v), 256'd0);
        next_cyc();
        chk("t8_opdv2", 256'(opd_v), 256'd0);
        $display("txn reset mid-split");

        // Saturation of the split counter
        for (int i = 0; i < 17; i++) begin
            set_pair(1'b1, 4'b1111, 5'd1, 5'd2, 5'd3, 5'd4);
            next_cyc();
            next_cyc();
            if (i == 13) chk("t9_cnt14", 256'(split_cnt), 256'd14);
        end
        set_pair(1'b0, 4'b0000, 5'd0, 5'd0, 5'd0, 5'd0);
        #1;
        chk("t9_cnt_sat", 256'(split_cnt), 256'd15);
        $display("txn 17 split pairs, counter=%0d", split_cnt);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
